risc_toy_ifetch: RTL and testbench

RISC_TOY_IFETCH -- requirements
Module: risc_toy_ifetch

---
 rtl/risc_toy_ifetch.sv | 81 ++++++++
 tb/tb_risc_toy_ifetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/risc_toy_ifetch.sv
// risc_toy_ifetch: instruction fetch with DEPTH-entry prefetch queue; define IFETCH_BYPASS_EN to forward a returning word straight to decode when the queue is empty
module risc_toy_ifetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        IREQ,
  output logic [29:0] IADDR,
  input  logic [31:0] INSTR,
  input  logic        REDIR,
  input  logic [31:0] REDIR_PC,
  output logic        ID_VALID,
  output logic [31:0] ID_INSTR,
  output logic [31:0] ID_PC,
  input  logic        ID_READY
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {FETCH, HOLD, FLUSH} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, rpc_q;
  logic inflight_q;
  logic [AW:0] count_q, count_d;
  logic [AW-1:0] rd_q, wr_q;
  logic [31:0] qi_mem [DEPTH];
  logic [31:0] qp_mem [DEPTH];
  logic credit, push, pop, bypass, head_v;
  // room left for everything queued plus the word still coming back
  assign credit = ({1'b0, count_q} + (AW+2)'(inflight_q)) < (AW+2)'(DEPTH);
  assign head_v = count_q != '0;
`ifdef IFETCH_BYPASS_EN
  assign bypass = inflight_q && !head_v && !REDIR;
`else
  assign bypass = 1'b0;
`endif
  assign push = inflight_q && !REDIR && !(bypass && ID_READY);
  assign pop  = head_v && ID_READY && !REDIR;
  // state register
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) state_q <= FETCH;
    else       state_q <= state_d;
  // next state: redirect wins, flush lasts one cycle, otherwise follow credit
  always_comb
    state_d = REDIR ? FLUSH : (state_q == FLUSH || credit) ? FETCH : HOLD;
  // outputs: requests only with credit in FETCH, decode sees the queue head or the bypassed word
  always_comb begin
    IREQ     = RSTN && state_q == FETCH && credit;
    IADDR    = pc_q[31:2];
    ID_VALID = head_v || bypass;
    ID_INSTR = head_v ? qi_mem[rd_q] : bypass ? INSTR : 32'h0;
    ID_PC    = head_v ? qp_mem[rd_q] : bypass ? rpc_q : 32'h0;
  end
  // next fetch pc and occupancy
  always_comb begin
    pc_d    = REDIR ? (REDIR_PC & ~32'h3) : IREQ ? pc_q + 32'd4 : pc_q;
    count_d = REDIR ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // fetch pc, in-flight tracking and queue pointers; a redirect drops everything pending
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      pc_q       <= RESET_PC;
      rpc_q      <= 32'h0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= IREQ && !REDIR;
      if (IREQ) rpc_q <= pc_q;
      rd_q       <= REDIR ? '0 : rd_q + AW'(pop);
      wr_q       <= REDIR ? '0 : wr_q + AW'(push);
    end
  // queue storage holds the word and the pc it was fetched from
  always_ff @(posedge CLK)
    if (push) begin
      qi_mem[wr_q] <= INSTR;
      qp_mem[wr_q] <= rpc_q;
    end
endmodule

// File: tb/tb_risc_toy_ifetch.sv
// tb_risc_toy_ifetch: random and directed checks of risc_toy_ifetch against a queue-based reference model
module tb_risc_toy_ifetch;
  localparam int DEPTH = 4;
  localparam int S_FETCH = 0, S_HOLD = 1, S_FLUSH = 2;
  logic CLK = 1'b0, RSTN = 1'b0;
  logic IREQ, ID_VALID, REDIR = 1'b0, ID_READY = 1'b1;
  logic [29:0] IADDR;
  logic [31:0] INSTR = 32'h0, REDIR_PC = 32'h0, ID_INSTR, ID_PC;
  logic w_ireq, w_valid;
  logic [29:0] w_iaddr;
  logic [31:0] w_instr, w_pc;
  int n_cmp = 0, n_err = 0;
  logic [31:0] m_q[$];
  int m_st, m_infl, ireq_cnt, wrap_idx = 4;
  logic [31:0] m_pc, m_infl_pc;
  logic last_ireq;
  logic [29:0] last_iaddr;
  logic [29:0] wrap_exp [4] = '{30'h3FFF_FFFE, 30'h3FFF_FFFF, 30'h0, 30'h1};

  risc_toy_ifetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .REDIR(REDIR), .REDIR_PC(REDIR_PC), .ID_VALID(ID_VALID),
    .ID_INSTR(ID_INSTR), .ID_PC(ID_PC), .ID_READY(ID_READY));

  risc_toy_ifetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .CLK(CLK), .RSTN(RSTN), .IREQ(w_ireq), .IADDR(w_iaddr), .INSTR(INSTR),
    .REDIR(REDIR), .REDIR_PC(REDIR_PC), .ID_VALID(w_valid),
    .ID_INSTR(w_instr), .ID_PC(w_pc), .ID_READY(ID_READY));

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_at(logic [29:0] a);
    return {a, 2'b00} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(logic [31:0] rpc);
    m_q.delete();
    m_st = S_FETCH;
    m_infl = 0;
    m_pc = rpc;
    m_infl_pc = 32'h0;
  endtask

  task automatic model_edge();
    bit credit, ireq, byp;
    credit = (m_q.size() + m_infl) < DEPTH;
    ireq = m_st == S_FETCH && credit;
    byp = 1'b0;
    if (REDIR) begin
      m_q.delete();
      m_infl = 0;
      m_pc = {REDIR_PC[31:2], 2'b00};
      m_st = S_FLUSH;
    end else begin
`ifdef IFETCH_BYPASS_EN
      byp = m_q.size() == 0 && m_infl != 0 && ID_READY;
`endif
      if (m_q.size() != 0 && ID_READY) void'(m_q.pop_front());
      if (m_infl != 0 && !byp) m_q.push_back(m_infl_pc);
      m_infl = ireq ? 1 : 0;
      m_infl_pc = m_pc;
      if (ireq) m_pc = m_pc + 32'd4;
      case (m_st)
        S_FETCH: m_st = credit ? S_FETCH : S_HOLD;
        S_HOLD:  m_st = credit ? S_FETCH : S_HOLD;
        default: m_st = S_FETCH;
      endcase
    end
  endtask

  task automatic cycle();
    bit exp_valid, exp_ireq;
    logic [31:0] exp_pc;
    @(negedge CLK);
    exp_ireq = m_st == S_FETCH && (m_q.size() + m_infl) < DEPTH;
    exp_valid = m_q.size() != 0;
    exp_pc = exp_valid ? m_q[0] : 32'h0;
`ifdef IFETCH_BYPASS_EN
    if (!exp_valid && m_infl != 0 && !REDIR) begin
      exp_valid = 1'b1;
      exp_pc = m_infl_pc;
    end
`endif
    check("ireq", {31'h0, IREQ}, {31'h0, exp_ireq});
    check("iaddr", {2'b00, IADDR}, {2'b00, m_pc[31:2]});
    check("id_valid", {31'h0, ID_VALID}, {31'h0, exp_valid});
    if (exp_valid) begin
      check("id_pc", ID_PC, exp_pc);
      check("id_instr", ID_INSTR, word_at(exp_pc[31:2]));
    end
    if (wrap_idx < 4) begin
      check("wrap_ireq", {31'h0, w_ireq}, 32'h1);
      check("wrap_iaddr", {2'b00, w_iaddr}, {2'b00, wrap_exp[wrap_idx]});
      wrap_idx++;
    end
    if (IREQ) ireq_cnt++;
    last_ireq = IREQ;
    last_iaddr = IADDR;
    @(posedge CLK);
    model_edge();
    #1;
    INSTR = last_ireq ? word_at(last_iaddr) : $urandom;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    REDIR = 1'b0;
    model_reset(32'h0);
    repeat (2) @(negedge CLK);
    check("rst_ireq", {31'h0, IREQ}, 32'h0);
    check("rst_valid", {31'h0, ID_VALID}, 32'h0);
    check("rst_instr", ID_INSTR, 32'h0);
    check("rst_pc", ID_PC, 32'h0);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    last_ireq = 1'b0;
  endtask

  initial begin
    ID_READY = 1'b1;
    do_reset();
    wrap_idx = 0;
    repeat (20) cycle();

    do_reset();
    ID_READY = 1'b0;
    ireq_cnt = 0;
    repeat (10) cycle();
    check("hold_ireqs", ireq_cnt, 4);
    ID_READY = 1'b1;
    repeat (15) cycle();

    ID_READY = 1'b0;
    for (int i = 0; i < 12 && m_q.size() != 3; i++) cycle();
    check("fill3", m_q.size(), 3);
    REDIR = 1'b1;
    REDIR_PC = 32'h0000_0103;
    cycle();
    REDIR = 1'b0;
    ID_READY = 1'b1;
    repeat (10) cycle();

    for (int i = 0; i < 400; i++) begin
      ID_READY = $urandom_range(0, 3) != 0;
      REDIR = $urandom_range(0, 19) == 0;
      REDIR_PC = $urandom;
      cycle();
    end
    REDIR = 1'b0;

    ID_READY = 1'b0;
    for (int i = 0; i < 12 && m_q.size() != 2; i++) cycle();
    check("fill2", m_q.size(), 2);
    #2;
    RSTN = 1'b0;
    #1;
    check("async_ireq", {31'h0, IREQ}, 32'h0);
    check("async_valid", {31'h0, ID_VALID}, 32'h0);
    ID_READY = 1'b1;
    do_reset();
    repeat (12) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
